// File: rtl/bullet_controller.sv
// bullet_controller
//   Per-tank projectile engine. A fire press launches one bullet from the tank
//   position on the next frame tick. The bullet then moves once per frame along
//   the direction the tank faced at launch. It dies on a hit, on the screen edge,
//   or when its lifetime runs out. A reload cooldown follows every death.
//
// Ports
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   frame_clk  in   frame strobe; a rising edge is one frame tick
//   fire       in   fire key (level); a rising edge requests a shot
//   fast_shot  in   speed upgrade; sampled at launch
//   TankX/Y    in   tank centre; sampled at launch
//   Dir        in   tank facing: 0 up, 1 right, 2 down, 3 left; sampled at launch
//   hit        in   collision flag; only looked at on tick cycles
//   BulletX/Y  out  bullet centre; holds its last value after the bullet dies
//   bullet_on  out  bullet live/visible
//   ready      out  idle with no pending shot (reload indicator)
module bullet_controller #(
  parameter int STEP      = 4,
  parameter int STEP_FAST = 8,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int LIFETIME  = 120,
  parameter int COOLDOWN  = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       fast_shot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Dir,
  input  logic       hit,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_on,
  output logic       ready
);

  localparam int LW = $clog2(LIFETIME + 1);
  localparam int CW = $clog2(COOLDOWN + 1);

  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN_S = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [9:0]      x_reg, x_next;
  logic [9:0]      y_reg, y_next;
  logic            on_reg, on_next;
  logic            ready_reg, ready_next;
  logic [1:0]      dir_reg, dir_next;
  logic [9:0]      step_reg, step_next;
  logic [LW-1:0]   life_reg, life_next;
  logic [CW-1:0]   cd_reg, cd_next;
  logic            fire_req_reg, fire_req_next;
  logic            frame_q_reg;
  logic            fire_q_reg;

  logic            tick;
  logic            fire_edge;
  logic            edge_kill;
  logic [10:0]     x_ext, y_ext, step_ext;

  assign tick      = frame_clk & ~frame_q_reg;
  assign fire_edge = fire & ~fire_q_reg;

  // The next position is checked in 11 bits so the kill happens before any
  // wrap-around of the 10-bit coordinates.
  assign x_ext    = {1'b0, x_reg};
  assign y_ext    = {1'b0, y_reg};
  assign step_ext = {1'b0, step_reg};

  always_comb begin
    edge_kill = 1'b0;
    case (dir_reg)
      2'd0:    edge_kill = (y_ext < step_ext);
      2'd1:    edge_kill = ((x_ext + step_ext) > X_LIM);
      2'd2:    edge_kill = ((y_ext + step_ext) > Y_LIM);
      default: edge_kill = (x_ext < step_ext);
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      on_reg       <= 1'b0;
      ready_reg    <= 1'b1;
      dir_reg      <= '0;
      step_reg     <= '0;
      life_reg     <= '0;
      cd_reg       <= '0;
      fire_req_reg <= 1'b0;
      frame_q_reg  <= 1'b0;
      fire_q_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      on_reg       <= on_next;
      ready_reg    <= ready_next;
      dir_reg      <= dir_next;
      step_reg     <= step_next;
      life_reg     <= life_next;
      cd_reg       <= cd_next;
      fire_req_reg <= fire_req_next;
      frame_q_reg  <= frame_clk;
      fire_q_reg   <= fire;
    end
  end

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    on_next       = on_reg;
    dir_next      = dir_reg;
    step_next     = step_reg;
    life_next     = life_reg;
    cd_next       = cd_reg;
    fire_req_next = fire_req_reg;

    case (state_reg)
      IDLE: begin
        on_next = 1'b0;
        if (fire_edge) fire_req_next = 1'b1;
        // A press landing on the tick cycle itself still launches on that tick.
        if (tick && (fire_req_reg || fire_edge)) begin
          state_next    = FLYING;
          x_next        = TankX;
          y_next        = TankY;
          dir_next      = Dir;
          step_next     = fast_shot ? 10'(STEP_FAST) : 10'(STEP);
          life_next     = LW'(LIFETIME - 1);
          on_next       = 1'b1;
          fire_req_next = 1'b0;
        end
      end

      FLYING: begin
        // Presses while a bullet is out are dropped, not queued.
        if (tick) begin
          if (hit || edge_kill || (life_reg == '0)) begin
            state_next = COOLDOWN_S;
            on_next    = 1'b0;
            cd_next    = CW'(COOLDOWN - 1);
          end else begin
            life_next = life_reg - 1'b1;
            case (dir_reg)
              2'd0:    y_next = y_reg - step_reg;
              2'd1:    x_next = x_reg + step_reg;
              2'd2:    y_next = y_reg + step_reg;
              default: x_next = x_reg - step_reg;
            endcase
          end
        end
      end

      default: begin
        on_next = 1'b0;
        if (tick) begin
          if (cd_reg == '0) state_next = IDLE;
          else              cd_next    = cd_reg - 1'b1;
        end
      end
    endcase

    ready_next = (state_next == IDLE) && !fire_req_next;
  end

  assign BulletX   = x_reg;
  assign BulletY   = y_reg;
  assign bullet_on = on_reg;
  assign ready     = ready_reg;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: directed scenarios plus a random
// run, all compared against a frame-level behavioural model of the projectile.
module tb_bullet_controller;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int LIFETIME = 120;
  localparam int COOLDOWN = 30;

  logic       clk = 1'b0;
  logic       reset, frame_clk, fire, fast_shot, hit;
  logic [9:0] tank_x, tank_y;
  logic [1:0] dir;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_on, ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a bullet is either absent-and-ready, in flight with an
  // age in frames, or reloading with a count of frames spent reloading.
  int   m_mode;     // 0 idle, 1 flying, 2 reloading
  logic m_on, m_req;
  int   m_x, m_y, m_dir, m_step, m_age, m_reload;

  bullet_controller dut (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .fire(fire),
    .fast_shot(fast_shot), .TankX(tank_x), .TankY(tank_y), .Dir(dir),
    .hit(hit), .BulletX(bullet_x), .BulletY(bullet_y),
    .bullet_on(bullet_on), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] dut_vec();
    return {bullet_on, bullet_x, bullet_y, ready};
  endfunction

  function automatic logic [21:0] model_vec();
    return {m_on, 10'(m_x), 10'(m_y), (m_mode == 0) && !m_req};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_on = 1'b0; m_req = 1'b0;
    m_x = 0; m_y = 0; m_dir = 0; m_step = 0; m_age = 0; m_reload = 0;
  endtask

  task automatic model_press();
    if (m_mode == 0) m_req = 1'b1;
  endtask

  task automatic model_tick(input logic h);
    int nx, ny;
    if (m_mode == 0) begin
      if (m_req) begin
        m_mode = 1; m_on = 1'b1; m_req = 1'b0;
        m_x = tank_x; m_y = tank_y; m_dir = dir;
        m_step = fast_shot ? 8 : 4; m_age = 1;
      end
    end else if (m_mode == 1) begin
      nx = m_x + ((m_dir == 1) ? m_step : (m_dir == 3) ? -m_step : 0);
      ny = m_y + ((m_dir == 2) ? m_step : (m_dir == 0) ? -m_step : 0);
      if (h || nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX || m_age >= LIFETIME) begin
        m_mode = 2; m_on = 1'b0; m_reload = 0;
      end else begin
        m_x = nx; m_y = ny; m_age++;
      end
    end else begin
      m_reload++;
      if (m_reload >= COOLDOWN) m_mode = 0;
    end
  endtask

  task automatic tick(input logic h);
    @(negedge clk); frame_clk = 1'b1; hit = h;
    @(negedge clk); frame_clk = 1'b0; hit = 1'b0;
    model_tick(h);
  endtask

  task automatic press();
    @(negedge clk); fire = 1'b1;
    @(negedge clk); fire = 1'b0;
    model_press();
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 22'h1) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 22'h1);
    end
    $display("reset: on=%0b x=%0d y=%0d ready=%0b", bullet_on, bullet_x, bullet_y, ready);
  endtask

  task automatic test_right_move();
    do_reset();
    tank_x = 10'd320; tank_y = 10'd240; dir = 2'd1; fast_shot = 1'b0;
    press(); tick(1'b0);
    checks++;
    if ({bullet_on, bullet_x, bullet_y} !== {1'b1, 10'd320, 10'd240}) begin
      errors++; $display("FAIL launch_pos: got on=%0b (%0d,%0d) expected on=1 (320,240)", bullet_on, bullet_x, bullet_y);
    end
    for (int i = 0; i < 3; i++) tick(1'b0);
    checks++;
    if ({bullet_x, bullet_y} !== {10'd332, 10'd240} || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL right_move: got (%0d,%0d) expected (332,240)", bullet_x, bullet_y);
    end
    $display("right_move: x=%0d y=%0d on=%0b", bullet_x, bullet_y, bullet_on);
  endtask

  task automatic test_up_edge();
    logic exp_ready;
    do_reset();
    tank_x = 10'd200; tank_y = 10'd10; dir = 2'd0; fast_shot = 1'b0;
    press(); tick(1'b0); tick(1'b0);
    checks++;
    if (bullet_y !== 10'd6) begin
      errors++; $display("FAIL up_y6: got %0d expected 6", bullet_y);
    end
    tick(1'b0);
    checks++;
    if (bullet_y !== 10'd2) begin
      errors++; $display("FAIL up_y2: got %0d expected 2", bullet_y);
    end
    tick(1'b0);
    checks++;
    if ({bullet_on, bullet_y, ready} !== {1'b0, 10'd2, 1'b0}) begin
      errors++; $display("FAIL up_edge_kill: got on=%0b y=%0d ready=%0b expected on=0 y=2 ready=0", bullet_on, bullet_y, ready);
    end
    for (int k = 1; k <= COOLDOWN; k++) begin
      tick(1'b0);
      exp_ready = (k == COOLDOWN);
      checks++;
      if (ready !== exp_ready || dut_vec() !== model_vec()) begin
        errors++; $display("FAIL cooldown_ready: tick %0d got ready=%0b expected %0b", k, ready, exp_ready);
      end
    end
    $display("up_edge: y=%0d ready=%0b after %0d reload ticks", bullet_y, ready, COOLDOWN);
  endtask

  task automatic test_hit();
    do_reset();
    tank_x = 10'd300; tank_y = 10'd100; dir = 2'd2; fast_shot = 1'b0;
    press(); tick(1'b0); tick(1'b0);
    @(negedge clk); hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    checks++;
    if ({bullet_on, bullet_y} !== {1'b1, 10'd104}) begin
      errors++; $display("FAIL hit_between_ticks: got on=%0b y=%0d expected on=1 y=104", bullet_on, bullet_y);
    end
    tick(1'b1);
    checks++;
    if ({bullet_on, bullet_y} !== {1'b0, 10'd104} || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL hit_kill: got on=%0b y=%0d expected on=0 y=104", bullet_on, bullet_y);
    end
    $display("hit: on=%0b y=%0d", bullet_on, bullet_y);
  endtask

  task automatic test_lifetime();
    do_reset();
    tank_x = 10'd50; tank_y = 10'd200; dir = 2'd1; fast_shot = 1'b0;
    press();
    for (int t = 1; t <= LIFETIME + 1; t++) begin
      tick(1'b0);
      if (t >= LIFETIME) begin
        checks++;
        if (bullet_on !== (t <= LIFETIME)) begin
          errors++; $display("FAIL lifetime: tick %0d got on=%0b expected %0b", t, bullet_on, t <= LIFETIME);
        end
      end
    end
    checks++;
    if (bullet_x !== 10'd526 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL lifetime_pos: got x=%0d expected 526", bullet_x);
    end
    $display("lifetime: on=%0b x=%0d", bullet_on, bullet_x);
  endtask

  task automatic test_fire_ignore();
    do_reset();
    tank_x = 10'd320; tank_y = 10'd240; dir = 2'd3; fast_shot = 1'b0;
    press(); tick(1'b0);
    press(); tick(1'b0);
    tick(1'b1);
    press();
    while (!((m_mode == 0) && !m_req)) tick(1'b0);
    checks++;
    if ({bullet_on, ready} !== 2'b01) begin
      errors++; $display("FAIL no_relaunch: got on=%0b ready=%0b expected on=0 ready=1", bullet_on, ready);
    end
    press();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL pending_ready: got %0b expected 0", ready);
    end
    tick(1'b0);
    checks++;
    if ({bullet_on, bullet_x} !== {1'b1, 10'd320} || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL relaunch: got on=%0b x=%0d expected on=1 x=320", bullet_on, bullet_x);
    end
    $display("fire_ignore: on=%0b x=%0d", bullet_on, bullet_x);
  endtask

  task automatic test_fast_and_reset();
    do_reset();
    tank_x = 10'd100; tank_y = 10'd50; dir = 2'd3; fast_shot = 1'b1;
    press(); tick(1'b0); tick(1'b0);
    checks++;
    if (bullet_x !== 10'd92) begin
      errors++; $display("FAIL fast_step: got x=%0d expected 92", bullet_x);
    end
    do_reset();
    checks++;
    if (dut_vec() !== 22'h1) begin
      errors++; $display("FAIL midflight_reset: got %h expected %h", dut_vec(), 22'h1);
    end
    press();
    @(negedge clk); reset = 1'b1; frame_clk = 1'b1;
    @(negedge clk); reset = 1'b0; frame_clk = 1'b0;
    model_reset();
    tick(1'b0);
    checks++;
    if ({bullet_on, ready} !== 2'b01) begin
      errors++; $display("FAIL reset_beats_tick: got on=%0b ready=%0b expected on=0 ready=1", bullet_on, ready);
    end
    $display("fast_reset: on=%0b x=%0d ready=%0b", bullet_on, bullet_x, ready);
    fast_shot = 1'b0;
  endtask

  task automatic test_random();
    int act;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      act = $urandom_range(0, 9);
      if (act <= 1) press();
      else if (act == 2) begin
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
      end else if (act == 3) begin
        tank_x = 10'($urandom_range(0, X_MAX));
        tank_y = 10'($urandom_range(0, Y_MAX));
        dir = 2'($urandom_range(0, 3));
        fast_shot = 1'($urandom_range(0, 1));
      end else if (act == 4) begin
        @(negedge clk); fire = 1'b1; frame_clk = 1'b1;
        @(negedge clk); fire = 1'b0; frame_clk = 1'b0;
        model_press(); model_tick(1'b0);
      end else tick($urandom_range(0, 15) == 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_step%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    $display("random: 600 steps, last on=%0b x=%0d y=%0d", bullet_on, bullet_x, bullet_y);
  endtask

  initial begin
    reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; fast_shot = 1'b0; hit = 1'b0;
    tank_x = '0; tank_y = '0; dir = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_right_move();
    test_up_edge();
    test_hit();
    test_lifetime();
    test_fire_ignore();
    test_fast_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
